// File: rtl/pad_oe_sequencer_pkg.sv
// Shared types and sizing helpers for the pad output-enable sequencer.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package pad_oe_sequencer_pkg;

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } pad_seq_state_e;

    // Number of enable groups; the last group may be partial.
    function automatic int ngroups(input int num_pads, input int group_size);
        return (num_pads + group_size - 1) / group_size;
    endfunction

endpackage

// File: rtl/pad_attr_regfile.sv
// Per-pad attribute register bank behind a single-cycle request/grant config port.
// Latency: 1 cycle from granted request to cfg_rvalid_o/cfg_rdata_o.
// Backpressure: none; every request is granted the same cycle, back-to-back allowed.
//
// Ports: clk_i/rst_ni clock and async active-low reset; cfg_req_i/cfg_we_i/
// cfg_addr_i/cfg_wdata_i request side; cfg_gnt_o/cfg_rvalid_o/cfg_rdata_o
// response side; pad_attr_o holds every attribute word for the pad ring.
module pad_attr_regfile #(
    parameter int NUM_PADS = 16,
    parameter int PADATTR  = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               cfg_req_i,
    input  logic                               cfg_we_i,
    input  logic [$clog2(NUM_PADS)-1:0]        cfg_addr_i,
    input  logic [PADATTR-1:0]                 cfg_wdata_i,
    output logic                               cfg_gnt_o,
    output logic                               cfg_rvalid_o,
    output logic [PADATTR-1:0]                 cfg_rdata_o,
    output logic [NUM_PADS-1:0][PADATTR-1:0]   pad_attr_o
);

    logic addr_ok;

    // Non-power-of-two pad counts leave unused addresses; those read as 0 and ignore writes.
    assign addr_ok   = (int'(cfg_addr_i) < NUM_PADS);
    assign cfg_gnt_o = cfg_req_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pad_attr_o   <= '0;
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_req_i;
            if (cfg_req_i) begin
                if (!addr_ok) begin
                    cfg_rdata_o <= '0;
                end else if (cfg_we_i) begin
                    pad_attr_o[cfg_addr_i] <= cfg_wdata_i;
                    // A write echoes the value just stored.
                    cfg_rdata_o            <= cfg_wdata_i;
                end else begin
                    cfg_rdata_o <= pad_attr_o[cfg_addr_i];
                end
            end
        end
    end

endmodule

// File: rtl/pad_oe_sequencer.sv
// Staggered group-wise output-enable ramp for the pad ring plus pad attribute bank.
// Latency: pad_oe_o is combinational from pad_oe_req_i; mask steps one group every STAGGER_CYCLES.
// Backpressure: none; en/dis requests are level/pulse controls, config port always grants.
//
// Ports: clk_i/rst_ni clock and async active-low reset; en_req_i/dis_req_i ramp
// requests (dis wins); busy_o/all_on_o registered state decodes; pad_oe_req_i ->
// pad_oe_o gated enables; pad_attr_o and cfg_* attribute bank and its config port.
module pad_oe_sequencer
    import pad_oe_sequencer_pkg::*;
#(
    parameter int NUM_PADS       = 16,
    parameter int PADATTR        = 16,
    parameter int GROUP_SIZE     = 4,
    parameter int STAGGER_CYCLES = 8
) (
    input  logic                               clk_i,
    input  logic                               rst_ni,
    input  logic                               en_req_i,
    input  logic                               dis_req_i,
    output logic                               busy_o,
    output logic                               all_on_o,
    input  logic [NUM_PADS-1:0]                pad_oe_req_i,
    output logic [NUM_PADS-1:0]                pad_oe_o,
    output logic [NUM_PADS-1:0][PADATTR-1:0]   pad_attr_o,
    input  logic                               cfg_req_i,
    input  logic                               cfg_we_i,
    input  logic [$clog2(NUM_PADS)-1:0]        cfg_addr_i,
    input  logic [PADATTR-1:0]                 cfg_wdata_i,
    output logic                               cfg_gnt_o,
    output logic                               cfg_rvalid_o,
    output logic [PADATTR-1:0]                 cfg_rdata_o
);

    localparam int NGROUPS = ngroups(NUM_PADS, GROUP_SIZE);
    localparam int CNT_W   = (STAGGER_CYCLES > 1) ? $clog2(STAGGER_CYCLES) : 1;

    localparam logic [CNT_W-1:0]   CNT_LOAD  = CNT_W'(STAGGER_CYCLES - 1);
    localparam logic [NGROUPS-1:0] MASK_ONE  = NGROUPS'(1);
    localparam logic [NGROUPS-1:0] MASK_FULL = '1;

    pad_seq_state_e     state;
    logic [NGROUPS-1:0] group_mask;
    logic [CNT_W-1:0]   stagger_cnt;
    logic [NGROUPS-1:0] mask_up;
    logic [NGROUPS-1:0] mask_dn;

    // The mask is always a thermometer code from group 0 upward, so enabling the
    // next group is a shift-in of a one and disabling the top group is a shift-out.
    assign mask_up = (group_mask << 1) | MASK_ONE;
    assign mask_dn = group_mask >> 1;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= OFF;
            group_mask  <= '0;
            stagger_cnt <= '0;
            busy_o      <= 1'b0;
            all_on_o    <= 1'b0;
        end else begin
            busy_o   <= (state == RAMP_UP) || (state == RAMP_DOWN);
            all_on_o <= (state == ON);
            unique case (state)
                OFF: begin
                    if (en_req_i && !dis_req_i) begin
                        group_mask  <= mask_up;
                        stagger_cnt <= CNT_LOAD;
                        state       <= (mask_up == MASK_FULL) ? ON : RAMP_UP;
                    end
                end
                RAMP_UP: begin
                    // A reversal freezes the counter for one cycle, then the
                    // remaining wait carries over into the ramp-down.
                    if (dis_req_i) begin
                        state <= RAMP_DOWN;
                    end else if (stagger_cnt == '0) begin
                        group_mask  <= mask_up;
                        stagger_cnt <= CNT_LOAD;
                        if (mask_up == MASK_FULL) begin
                            state <= ON;
                        end
                    end else begin
                        stagger_cnt <= stagger_cnt - 1'b1;
                    end
                end
                ON: begin
                    if (dis_req_i) begin
                        group_mask  <= mask_dn;
                        stagger_cnt <= CNT_LOAD;
                        state       <= (mask_dn == '0) ? OFF : RAMP_DOWN;
                    end
                end
                RAMP_DOWN: begin
                    if (en_req_i && !dis_req_i) begin
                        state <= RAMP_UP;
                    end else if (stagger_cnt == '0) begin
                        group_mask  <= mask_dn;
                        stagger_cnt <= CNT_LOAD;
                        if (mask_dn == '0) begin
                            state <= OFF;
                        end
                    end else begin
                        stagger_cnt <= stagger_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_PADS; k++) begin : g_gate
        assign pad_oe_o[k] = pad_oe_req_i[k] & group_mask[k / GROUP_SIZE];
    end

    pad_attr_regfile #(
        .NUM_PADS (NUM_PADS),
        .PADATTR  (PADATTR)
    ) u_attr (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .cfg_req_i    (cfg_req_i),
        .cfg_we_i     (cfg_we_i),
        .cfg_addr_i   (cfg_addr_i),
        .cfg_wdata_i  (cfg_wdata_i),
        .cfg_gnt_o    (cfg_gnt_o),
        .cfg_rvalid_o (cfg_rvalid_o),
        .cfg_rdata_o  (cfg_rdata_o),
        .pad_attr_o   (pad_attr_o)
    );

endmodule

// File: tb/tb_pad_oe_sequencer.sv
// Bench for pad_oe_sequencer: default instance (16 pads) and a partial-group instance (10 pads).
// Latency: n/a.
// Backpressure: n/a.
module tb_pad_oe_sequencer;

    localparam int S  = 8;
    localparam int GS = 4;
    localparam int PA = 16;
    localparam int N0 = 16;
    localparam int N1 = 10;
    localparam int NG0 = 4;   // ceil(16/4)
    localparam int NG1 = 3;   // ceil(10/4)

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0_n = 1'b0, rst1_n = 1'b0;
    logic en0 = 0, dis0 = 0, en1 = 0, dis1 = 0;
    logic [N0-1:0] req0 = '0, oe0;
    logic [N1-1:0] req1 = '0, oe1;
    logic busy0, busy1, allon0, allon1;
    logic [N0-1:0][PA-1:0] attr0;
    logic [N1-1:0][PA-1:0] attr1;
    logic creq0 = 0, cwe0 = 0, creq1 = 0, cwe1 = 0;
    logic [3:0] caddr0 = '0, caddr1 = '0;
    logic [PA-1:0] cwd0 = '0, cwd1 = '0;
    logic gnt0, gnt1, rv0, rv1;
    logic [PA-1:0] rd0, rd1;

    pad_oe_sequencer dut0 (
        .clk_i(clk), .rst_ni(rst0_n), .en_req_i(en0), .dis_req_i(dis0),
        .busy_o(busy0), .all_on_o(allon0), .pad_oe_req_i(req0), .pad_oe_o(oe0),
        .pad_attr_o(attr0), .cfg_req_i(creq0), .cfg_we_i(cwe0), .cfg_addr_i(caddr0),
        .cfg_wdata_i(cwd0), .cfg_gnt_o(gnt0), .cfg_rvalid_o(rv0), .cfg_rdata_o(rd0)
    );

    pad_oe_sequencer #(.NUM_PADS(N1), .PADATTR(PA), .GROUP_SIZE(GS), .STAGGER_CYCLES(S)) dut1 (
        .clk_i(clk), .rst_ni(rst1_n), .en_req_i(en1), .dis_req_i(dis1),
        .busy_o(busy1), .all_on_o(allon1), .pad_oe_req_i(req1), .pad_oe_o(oe1),
        .pad_attr_o(attr1), .cfg_req_i(creq1), .cfg_we_i(cwe1), .cfg_addr_i(caddr1),
        .cfg_wdata_i(cwd1), .cfg_gnt_o(gnt1), .cfg_rvalid_o(rv1), .cfg_rdata_o(rd1)
    );

    int errors = 0;
    int checks = 0;
    int t = 0;

    // Reference model: number of groups enabled, ramp direction, and the absolute
    // edge index at which the next group step is due.
    int lvl[2], dir[2], nxt[2];
    logic [PA-1:0] am0[N0];
    logic [PA-1:0] am1[N1];
    logic          rv_exp[2];
    logic [PA-1:0] rd_exp[2];

    function automatic logic [15:0] exp_oe(input int n, input logic [15:0] req, input int lv);
        logic [15:0] r = '0;
        for (int k = 0; k < n; k++) if (k / GS < lv) r[k] = req[k];
        return r;
    endfunction

    task automatic model_reset(input int d);
        lvl[d] = 0; dir[d] = 0; nxt[d] = 0;
        rv_exp[d] = 1'b0; rd_exp[d] = '0;
        if (d == 0) for (int k = 0; k < N0; k++) am0[k] = '0;
        else        for (int k = 0; k < N1; k++) am1[k] = '0;
    endtask

    task automatic model_seq(input int d, input logic en, input logic dis);
        int n = (d == 0) ? NG0 : NG1;
        if (lvl[d] == 0) begin
            if (en && !dis) begin lvl[d] = 1; dir[d] = 1; nxt[d] = t + S; end
        end else if (lvl[d] == n) begin
            if (dis) begin lvl[d] = n - 1; dir[d] = -1; nxt[d] = t + S; end
        end else if (dir[d] > 0 && dis) begin
            dir[d] = -1; nxt[d] = nxt[d] + 1;
        end else if (dir[d] < 0 && en && !dis) begin
            dir[d] = 1; nxt[d] = nxt[d] + 1;
        end else if (t == nxt[d]) begin
            lvl[d] = lvl[d] + dir[d]; nxt[d] = t + S;
        end
    endtask

    // One clock: inputs already set (away from the edge), model advanced at the
    // edge, all outputs compared against the model on the following falling edge.
    task automatic tick();
        int pl0, pl1;
        logic [N0-1:0][PA-1:0] ea0;
        logic [N1-1:0][PA-1:0] ea1;
        logic [15:0] eo;
        @(posedge clk);
        t++;
        pl0 = lvl[0]; pl1 = lvl[1];
        if (!rst0_n) begin
            model_reset(0); pl0 = 0;
        end else begin
            model_seq(0, en0, dis0);
            rv_exp[0] = creq0;
            if (creq0) begin
                if (cwe0) begin am0[caddr0] = cwd0; rd_exp[0] = cwd0; end
                else rd_exp[0] = am0[caddr0];
            end
        end
        if (!rst1_n) begin
            model_reset(1); pl1 = 0;
        end else begin
            model_seq(1, en1, dis1);
            rv_exp[1] = creq1;
            if (creq1) begin
                if (int'(caddr1) >= N1) rd_exp[1] = '0;
                else if (cwe1) begin am1[caddr1] = cwd1; rd_exp[1] = cwd1; end
                else rd_exp[1] = am1[caddr1];
            end
        end
        @(negedge clk);
        for (int k = 0; k < N0; k++) ea0[k] = am0[k];
        for (int k = 0; k < N1; k++) ea1[k] = am1[k];
        eo = exp_oe(N0, req0, lvl[0]);
        checks++; if (oe0 !== eo) begin errors++; $display("FAIL m0_oe t=%0d got=%h exp=%h", t, oe0, eo); end
        checks++; if (busy0 !== (pl0 > 0 && pl0 < NG0)) begin errors++; $display("FAIL m0_busy t=%0d got=%b", t, busy0); end
        checks++; if (allon0 !== (pl0 == NG0)) begin errors++; $display("FAIL m0_allon t=%0d got=%b", t, allon0); end
        checks++; if (rv0 !== rv_exp[0]) begin errors++; $display("FAIL m0_rvalid t=%0d got=%b exp=%b", t, rv0, rv_exp[0]); end
        if (rv_exp[0]) begin
            checks++; if (rd0 !== rd_exp[0]) begin errors++; $display("FAIL m0_rdata t=%0d got=%h exp=%h", t, rd0, rd_exp[0]); end
        end
        checks++; if (attr0 !== ea0) begin errors++; $display("FAIL m0_attr t=%0d", t); end
        eo = exp_oe(N1, {6'b0, req1}, lvl[1]);
        checks++; if ({6'b0, oe1} !== eo) begin errors++; $display("FAIL m1_oe t=%0d got=%h exp=%h", t, oe1, eo); end
        checks++; if (busy1 !== (pl1 > 0 && pl1 < NG1)) begin errors++; $display("FAIL m1_busy t=%0d got=%b", t, busy1); end
        checks++; if (allon1 !== (pl1 == NG1)) begin errors++; $display("FAIL m1_allon t=%0d got=%b", t, allon1); end
        checks++; if (rv1 !== rv_exp[1]) begin errors++; $display("FAIL m1_rvalid t=%0d got=%b exp=%b", t, rv1, rv_exp[1]); end
        if (rv_exp[1]) begin
            checks++; if (rd1 !== rd_exp[1]) begin errors++; $display("FAIL m1_rdata t=%0d got=%h exp=%h", t, rd1, rd_exp[1]); end
        end
        checks++; if (attr1 !== ea1) begin errors++; $display("FAIL m1_attr t=%0d", t); end
    endtask

    task automatic test_reset();
        model_reset(0); model_reset(1);
        rst0_n = 1'b0; rst1_n = 1'b0;
        #12;
        checks++; if (oe0 !== '0 || busy0 !== 1'b0 || allon0 !== 1'b0) begin errors++; $display("FAIL reset_seq0 oe=%h busy=%b allon=%b exp=0", oe0, busy0, allon0); end
        checks++; if (attr0 !== '0 || rv0 !== 1'b0 || rd0 !== '0) begin errors++; $display("FAIL reset_cfg0 rv=%b rd=%h exp=0", rv0, rd0); end
        checks++; if (oe1 !== '0 || busy1 !== 1'b0 || allon1 !== 1'b0 || attr1 !== '0) begin errors++; $display("FAIL reset_dut1 oe=%h busy=%b", oe1, busy1); end
        @(negedge clk);
        rst0_n = 1'b1; rst1_n = 1'b1;
        repeat (3) tick();
    endtask

    task automatic test_ramp_up();
        int cyc[4] = '{1, 9, 17, 25};
        logic [15:0] val[4] = '{16'h000F, 16'h00FF, 16'h0FFF, 16'hFFFF};
        req0 = '1;
        en0 = 1'b1; tick(); en0 = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            if (c > 1) tick();
            for (int i = 0; i < 4; i++)
                if (c == cyc[i]) begin
                    checks++; if (oe0 !== val[i]) begin errors++; $display("FAIL up_c%0d oe=%h exp=%h", c, oe0, val[i]); end
                end
            if (c == 25) begin checks++; if (allon0 !== 1'b0) begin errors++; $display("FAIL up_allon_c25 got=%b exp=0", allon0); end end
            if (c == 26) begin checks++; if (allon0 !== 1'b1) begin errors++; $display("FAIL up_allon_c26 got=%b exp=1", allon0); end end
        end
    endtask

    task automatic test_ramp_down();
        int cyc[4] = '{1, 9, 17, 25};
        logic [15:0] val[4] = '{16'h0FFF, 16'h00FF, 16'h000F, 16'h0000};
        dis0 = 1'b1; tick(); dis0 = 1'b0;
        for (int c = 1; c <= 26; c++) begin
            if (c > 1) tick();
            for (int i = 0; i < 4; i++)
                if (c == cyc[i]) begin
                    checks++; if (oe0 !== val[i]) begin errors++; $display("FAIL dn_c%0d oe=%h exp=%h", c, oe0, val[i]); end
                end
            if (c == 24) begin checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL dn_busy_c24 got=%b exp=1", busy0); end end
            if (c == 26) begin checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL dn_busy_c26 got=%b exp=0", busy0); end end
        end
    endtask

    task automatic test_reverse();
        logic [15:0] e;
        en0 = 1'b1; tick(); en0 = 1'b0;
        for (int c = 2; c <= 10; c++) tick();
        dis0 = 1'b1; tick(); dis0 = 1'b0;
        for (int c = 11; c <= 27; c++) begin
            if (c > 11) tick();
            e = (c < 18) ? 16'h00FF : (c < 26) ? 16'h000F : 16'h0000;
            if (c == 11 || c == 17 || c == 18 || c == 25 || c == 26) begin
                checks++; if (oe0 !== e) begin errors++; $display("FAIL rev_c%0d oe=%h exp=%h", c, oe0, e); end
            end
        end
        repeat (3) tick();
    endtask

    task automatic test_simultaneous();
        en0 = 1'b1; dis0 = 1'b1; tick(); en0 = 1'b0; dis0 = 1'b0;
        checks++; if (oe0 !== '0) begin errors++; $display("FAIL simul_oe got=%h exp=0", oe0); end
        tick();
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL simul_busy got=%b exp=0", busy0); end
        repeat (2) tick();
    endtask

    task automatic test_cfg();
        creq0 = 1'b1; cwe0 = 1'b1; caddr0 = 4'd3; cwd0 = 16'hA5A5;
        #1;
        checks++; if (gnt0 !== 1'b1) begin errors++; $display("FAIL cfg_gnt got=%b exp=1", gnt0); end
        tick();
        checks++; if (attr0[3] !== 16'hA5A5 || rv0 !== 1'b1) begin errors++; $display("FAIL cfg_wr3 attr=%h rv=%b exp=a5a5/1", attr0[3], rv0); end
        cwe0 = 1'b0; tick();
        checks++; if (rd0 !== 16'hA5A5 || rv0 !== 1'b1) begin errors++; $display("FAIL cfg_rd3 rd=%h rv=%b exp=a5a5/1", rd0, rv0); end
        cwe0 = 1'b1; caddr0 = 4'd15; cwd0 = 16'h1234; tick();
        checks++; if (rd0 !== 16'h1234) begin errors++; $display("FAIL cfg_wr15 rd=%h exp=1234", rd0); end
        creq0 = 1'b0; cwe0 = 1'b0; tick();
        checks++; if (rv0 !== 1'b0) begin errors++; $display("FAIL cfg_idle rv=%b exp=0", rv0); end
        creq1 = 1'b1; cwe1 = 1'b0; caddr1 = 4'd12; tick();
        checks++; if (rd1 !== '0 || rv1 !== 1'b1) begin errors++; $display("FAIL cfg_oor_rd rd=%h rv=%b exp=0/1", rd1, rv1); end
        cwe1 = 1'b1; caddr1 = 4'd13; cwd1 = 16'hFFFF; tick();
        checks++; if (attr1 !== '0 || rd1 !== '0) begin errors++; $display("FAIL cfg_oor_wr rd=%h exp=0", rd1); end
        caddr1 = 4'd9; cwd1 = 16'h5A5A; tick();
        checks++; if (attr1[9] !== 16'h5A5A) begin errors++; $display("FAIL cfg_wr9 attr=%h exp=5a5a", attr1[9]); end
        creq1 = 1'b0; cwe1 = 1'b0; tick();
    endtask

    task automatic test_partial_reset();
        req1 = '1;
        en1 = 1'b1; tick(); en1 = 1'b0;
        checks++; if (oe1 !== 10'h00F) begin errors++; $display("FAIL part_c1 oe=%h exp=00f", oe1); end
        repeat (8) tick();
        checks++; if (oe1 !== 10'h0FF) begin errors++; $display("FAIL part_c9 oe=%h exp=0ff", oe1); end
        repeat (8) tick();
        checks++; if (oe1 !== 10'h3FF) begin errors++; $display("FAIL part_c17 oe=%h exp=3ff", oe1); end
        tick();
        checks++; if (allon1 !== 1'b1) begin errors++; $display("FAIL part_allon got=%b exp=1", allon1); end
        dis1 = 1'b1; tick(); dis1 = 1'b0;
        repeat (20) tick();
        en1 = 1'b1; tick(); en1 = 1'b0;
        repeat (11) tick();
        #2 rst1_n = 1'b0;
        #1;
        checks++; if (oe1 !== '0 || busy1 !== 1'b0) begin errors++; $display("FAIL async_rst oe=%h busy=%b exp=0/0", oe1, busy1); end
        checks++; if (attr1 !== '0) begin errors++; $display("FAIL async_rst_attr attr9=%h exp=0", attr1[9]); end
        model_reset(1);
        tick();
        rst1_n = 1'b1;
        repeat (12) tick();
        checks++; if (oe1 !== '0) begin errors++; $display("FAIL rst_stays_off oe=%h exp=0", oe1); end
        en1 = 1'b1; tick(); en1 = 1'b0;
        checks++; if (oe1 !== 10'h00F) begin errors++; $display("FAIL rst_restart oe=%h exp=00f", oe1); end
        repeat (30) tick();
    endtask

    task automatic test_random();
        for (int i = 0; i < 1500; i++) begin
            en0 = ($urandom_range(0, 11) == 0); dis0 = ($urandom_range(0, 13) == 0);
            en1 = ($urandom_range(0, 11) == 0); dis1 = ($urandom_range(0, 13) == 0);
            if ($urandom_range(0, 3) == 0) begin req0 = N0'($urandom); req1 = N1'($urandom); end
            creq0 = $urandom_range(0, 1) == 1; cwe0 = $urandom_range(0, 1) == 1;
            caddr0 = 4'($urandom); cwd0 = PA'($urandom);
            creq1 = $urandom_range(0, 1) == 1; cwe1 = $urandom_range(0, 1) == 1;
            caddr1 = 4'($urandom); cwd1 = PA'($urandom);
            tick();
        end
        en0 = 0; dis0 = 0; en1 = 0; dis1 = 0; creq0 = 0; creq1 = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_reverse();
        test_simultaneous();
        test_cfg();
        test_partial_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
